// File: rtl/bist_pkg.sv
// Shared types and constants for the BIST campaign sequencer.
// Defines the FSM encoding, the CONF word layout and the result sentinels.
package bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEL,
        ST_SETUP,
        ST_RUN,
        ST_SAMPLE,
        ST_FIN
    } state_t;

    localparam int CONF_MODE_BIT = 12;
    localparam int CONF_NUM_MSB  = 11;
    localparam int CONF_NUM_LSB  = 8;
    localparam int CONF_LEN_MSB  = 7;
    localparam int CONF_LEN_LSB  = 0;

    localparam logic [3:0] ERR_PASS        = 4'h0;
    localparam logic [4:0] FIRST_FAIL_NONE = 5'd31;
    localparam logic [4:0] USER_IDX        = 5'd16;

    function automatic logic [12:0] make_conf(input logic       user,
                                              input logic [3:0] num,
                                              input logic [7:0] len);
        logic [12:0] conf;
        conf = '0;
        conf[CONF_MODE_BIT]              = user;
        conf[CONF_NUM_MSB:CONF_NUM_LSB]  = num;
        conf[CONF_LEN_MSB:CONF_LEN_LSB]  = len;
        return conf;
    endfunction

endpackage

// File: rtl/bist_prio_enc.sv
// Lowest-set-bit priority encoder over the pending preset-test mask.
module bist_prio_enc (
    input  logic [15:0] mask,
    output logic [3:0]  idx,
    output logic        valid
);

    // Scan high to low so the lowest set bit is the last one to win.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            if (mask[i]) begin
                idx   = 4'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bist_sequencer.sv
// Campaign controller: walks preset tests then an optional user test,
// running each through setup/run/sample and accumulating results.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | waiting for start; results hold
// ST_SEL    | pick next pending test and load CONF, or finish
// ST_SETUP  | enable low, CONF stable for SETUP_CYCLES
// ST_RUN    | enable high for RUN_CYCLES
// ST_SAMPLE | enable low, status sampled and results updated
// ST_FIN    | one-cycle done pulse, back to idle
module bist_sequencer
    import bist_pkg::*;
#(
    parameter int SETUP_CYCLES = 2,
    parameter int RUN_CYCLES   = 300
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] test_mask,
    input  logic        user_run,
    input  logic [7:0]  user_len,
    output logic        bist_enable,
    output logic [12:0] bist_conf_reg,
    input  logic [15:0] bist_status_reg,
    output logic        busy,
    output logic        done,
    output logic        aborted,
    output logic [15:0] pass_mask,
    output logic [15:0] fail_mask,
    output logic        user_fail,
    output logic [4:0]  fail_count,
    output logic [4:0]  first_fail_test,
    output logic [15:0] first_fail_stat
);

    localparam int MAX_CYC = (SETUP_CYCLES > RUN_CYCLES) ? SETUP_CYCLES : RUN_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_LOAD   = CNT_W'(RUN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t state_q, state_d;

    logic [15:0]      pend_mask_q;
    logic             pend_user_q;
    logic [7:0]       len_q;
    logic [CNT_W-1:0] cnt_q;
    logic [12:0]      conf_q;
    logic             aborted_q;
    logic [15:0]      pass_mask_q;
    logic [15:0]      fail_mask_q;
    logic             user_fail_q;
    logic [4:0]       fail_count_q;
    logic [4:0]       first_fail_test_q;
    logic [15:0]      first_fail_stat_q;

    logic [3:0] enc_idx;
    logic       enc_valid;
    logic       cur_user;
    logic [3:0] cur_num;
    logic       active;

    bist_prio_enc u_prio_enc (
        .mask  (pend_mask_q),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

    assign cur_user = conf_q[CONF_MODE_BIT];
    assign cur_num  = conf_q[CONF_NUM_MSB:CONF_NUM_LSB];
    assign active   = (state_q != ST_IDLE) && (state_q != ST_FIN);

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (start && !abort) state_d = ST_SEL;
            ST_SEL: begin
                if (abort)                         state_d = ST_FIN;
                else if (enc_valid || pend_user_q) state_d = ST_SETUP;
                else                               state_d = ST_FIN;
            end
            ST_SETUP: begin
                if (abort)              state_d = ST_FIN;
                else if (cnt_q == '0)   state_d = ST_RUN;
            end
            ST_RUN: begin
                if (abort)              state_d = ST_FIN;
                else if (cnt_q == '0)   state_d = ST_SAMPLE;
            end
            ST_SAMPLE: state_d = abort ? ST_FIN : ST_SEL;
            ST_FIN:    state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_mask_q       <= '0;
            pend_user_q       <= 1'b0;
            len_q             <= '0;
            cnt_q             <= '0;
            conf_q            <= '0;
            aborted_q         <= 1'b0;
            pass_mask_q       <= '0;
            fail_mask_q       <= '0;
            user_fail_q       <= 1'b0;
            fail_count_q      <= '0;
            first_fail_test_q <= FIRST_FAIL_NONE;
            first_fail_stat_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && !abort) begin
                        pend_mask_q       <= test_mask;
                        pend_user_q       <= user_run;
                        len_q             <= user_len;
                        aborted_q         <= 1'b0;
                        pass_mask_q       <= '0;
                        fail_mask_q       <= '0;
                        user_fail_q       <= 1'b0;
                        fail_count_q      <= '0;
                        first_fail_test_q <= FIRST_FAIL_NONE;
                        first_fail_stat_q <= '0;
                    end
                end
                ST_SEL: begin
                    if (!abort) begin
                        if (enc_valid) begin
                            pend_mask_q[enc_idx] <= 1'b0;
                            conf_q               <= make_conf(1'b0, enc_idx, 8'h00);
                            cnt_q                <= SETUP_LOAD;
                        end else if (pend_user_q) begin
                            pend_user_q <= 1'b0;
                            conf_q      <= make_conf(1'b1, 4'h0, len_q);
                            cnt_q       <= SETUP_LOAD;
                        end
                    end
                end
                ST_SETUP: begin
                    if (cnt_q == '0) cnt_q <= RUN_LOAD;
                    else             cnt_q <= cnt_q - CNT_ONE;
                end
                ST_RUN: begin
                    if (cnt_q != '0) cnt_q <= cnt_q - CNT_ONE;
                end
                ST_SAMPLE: begin
                    // An abort arriving in the sample cycle discards this test's result.
                    if (!abort) begin
                        if (bist_status_reg[3:0] == ERR_PASS) begin
                            if (!cur_user) pass_mask_q[cur_num] <= 1'b1;
                        end else begin
                            if (cur_user) user_fail_q          <= 1'b1;
                            else          fail_mask_q[cur_num] <= 1'b1;
                            if (fail_count_q != 5'd31) fail_count_q <= fail_count_q + 5'd1;
                            if (first_fail_test_q == FIRST_FAIL_NONE) begin
                                first_fail_test_q <= cur_user ? USER_IDX : {1'b0, cur_num};
                                first_fail_stat_q <= bist_status_reg;
                            end
                        end
                    end
                end
                default: ;
            endcase
            if (abort && active) aborted_q <= 1'b1;
        end
    end

    assign bist_enable     = (state_q == ST_RUN);
    assign busy            = active;
    assign done            = (state_q == ST_FIN);
    assign bist_conf_reg   = conf_q;
    assign aborted         = aborted_q;
    assign pass_mask       = pass_mask_q;
    assign fail_mask       = fail_mask_q;
    assign user_fail       = user_fail_q;
    assign fail_count      = fail_count_q;
    assign first_fail_test = first_fail_test_q;
    assign first_fail_stat = first_fail_stat_q;

endmodule

// File: tb/tb_bist_sequencer.sv
// Self-checking bench for bist_sequencer: scripted BIST status model,
// campaign-level reference model, and an enable/conf monitor.
module tb_bist_sequencer;
    localparam int S = 2;
    localparam int R = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] test_mask = '0;
    logic        user_run = 1'b0;
    logic [7:0]  user_len = '0;
    logic        bist_enable;
    logic [12:0] bist_conf_reg;
    logic [15:0] bist_status_reg;
    logic        busy, done, aborted, user_fail;
    logic [15:0] pass_mask, fail_mask, first_fail_stat;
    logic [4:0]  fail_count, first_fail_test;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] status_tbl [17];
    int          sidx;

    bist_sequencer #(.SETUP_CYCLES(S), .RUN_CYCLES(R)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .test_mask(test_mask), .user_run(user_run), .user_len(user_len),
        .bist_enable(bist_enable), .bist_conf_reg(bist_conf_reg),
        .bist_status_reg(bist_status_reg), .busy(busy), .done(done),
        .aborted(aborted), .pass_mask(pass_mask), .fail_mask(fail_mask),
        .user_fail(user_fail), .fail_count(fail_count),
        .first_fail_test(first_fail_test), .first_fail_stat(first_fail_stat)
    );

    always #5 clk = ~clk;

    always_comb begin
        sidx = bist_conf_reg[12] ? 16 : int'(bist_conf_reg[11:8]);
        bist_status_reg = status_tbl[sidx];
    end

    // Monitor: records conf and length of every enable-high window.
    logic [12:0] run_conf_q[$];
    int          run_len_q[$];
    logic [12:0] conf_run = '0;
    int          run_len = 0, off_len = 0, done_cnt = 0, gap_err = 0, conf_err = 0;
    bit          en_prev = 1'b0, had_run = 1'b0;

    always @(negedge clk) begin
        if (bist_enable) begin
            if (!en_prev) begin
                conf_run <= bist_conf_reg;
                run_len  <= 1;
                if (had_run && off_len < S + 2) gap_err <= gap_err + 1;
            end else begin
                run_len <= run_len + 1;
                if (bist_conf_reg != conf_run) conf_err <= conf_err + 1;
            end
        end else begin
            if (en_prev) begin
                run_conf_q.push_back(conf_run);
                run_len_q.push_back(run_len);
                had_run <= 1'b1;
                off_len <= 1;
            end else begin
                off_len <= off_len + 1;
            end
        end
        en_prev <= bist_enable;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic set_all_status(input logic [15:0] v);
        for (int i = 0; i < 17; i++) status_tbl[i] = v;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || bist_enable !== 1'b0) begin
            n_errors++; $display("FAIL reset_ctrl: busy=%b done=%b en=%b, want 0 0 0", busy, done, bist_enable);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({aborted, pass_mask, fail_mask, user_fail, fail_count, first_fail_test, first_fail_stat, bist_conf_reg}
            !== {1'b0, 16'h0, 16'h0, 1'b0, 5'd0, 5'd31, 16'h0, 13'h0}) begin
            n_errors++;
            $display("FAIL reset_vals: ab=%b pm=%h fm=%h uf=%b fc=%0d fft=%0d ffs=%h conf=%h, want 0 0 0 0 0 31 0 0",
                     aborted, pass_mask, fail_mask, user_fail, fail_count, first_fail_test, first_fail_stat, bist_conf_reg);
        end
    endtask

    task automatic test_campaign(input logic [15:0] m, input logic u, input logic [7:0] l, input string nm);
        logic [15:0] e_pass, e_fail, e_ffs;
        logic        e_uf;
        int          e_cnt, cyc, q0, d0;
        logic [4:0]  e_fft;
        logic [12:0] e_conf[$];
        e_pass = '0; e_fail = '0; e_uf = 1'b0; e_cnt = 0; e_fft = 5'd31; e_ffs = '0;
        for (int i = 0; i < 16; i++) begin
            if (m[i]) begin
                e_conf.push_back(13'(i << 8));
                if (status_tbl[i][3:0] == 4'h0) e_pass[i] = 1'b1;
                else begin
                    e_fail[i] = 1'b1; e_cnt++;
                    if (e_fft == 5'd31) begin e_fft = 5'(i); e_ffs = status_tbl[i]; end
                end
            end
        end
        if (u) begin
            e_conf.push_back(13'h1000 | 13'(l));
            if (status_tbl[16][3:0] != 4'h0) begin
                e_uf = 1'b1; e_cnt++;
                if (e_fft == 5'd31) begin e_fft = 5'd16; e_ffs = status_tbl[16]; end
            end
        end
        q0 = run_conf_q.size(); d0 = done_cnt;
        @(posedge clk); #1;
        test_mask = m; user_run = u; user_len = l; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; test_mask = 16'($urandom); user_run = ~u; user_len = 8'($urandom);
        cyc = 1;
        while (!done && cyc < 5000) begin @(posedge clk); #1; cyc++; end
        n_checks++;
        if (cyc !== e_conf.size() * (S + R + 2) + 2) begin
            n_errors++; $display("FAIL %s latency: got %0d cycles, want %0d", nm, cyc, e_conf.size() * (S + R + 2) + 2);
        end
        @(negedge clk); #1;
        n_checks++;
        if (done_cnt - d0 !== 1 || busy !== 1'b0 || aborted !== 1'b0) begin
            n_errors++; $display("FAIL %s done: pulses=%0d busy=%b ab=%b, want 1 0 0", nm, done_cnt - d0, busy, aborted);
        end
        n_checks++;
        if ({pass_mask, fail_mask, user_fail, fail_count, first_fail_test, first_fail_stat}
            !== {e_pass, e_fail, e_uf, 5'(e_cnt), e_fft, e_ffs}) begin
            n_errors++;
            $display("FAIL %s results: pm=%h fm=%h uf=%b fc=%0d fft=%0d ffs=%h, want %h %h %b %0d %0d %h", nm,
                     pass_mask, fail_mask, user_fail, fail_count, first_fail_test, first_fail_stat,
                     e_pass, e_fail, e_uf, e_cnt, e_fft, e_ffs);
        end
        n_checks++;
        if (run_conf_q.size() - q0 !== e_conf.size() || gap_err !== 0 || conf_err !== 0) begin
            n_errors++; $display("FAIL %s runs: count=%0d gap_err=%0d conf_err=%0d, want %0d 0 0",
                                 nm, run_conf_q.size() - q0, gap_err, conf_err, e_conf.size());
        end else begin
            for (int k = 0; k < e_conf.size(); k++) begin
                n_checks++;
                if (run_conf_q[q0 + k] !== e_conf[k] || run_len_q[q0 + k] !== R) begin
                    n_errors++; $display("FAIL %s run%0d: conf=%h len=%0d, want %h %0d",
                                         nm, k, run_conf_q[q0 + k], run_len_q[q0 + k], e_conf[k], R);
                end
            end
        end
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b0 || (e_conf.size() > 0 && bist_conf_reg !== e_conf[e_conf.size() - 1])
            || pass_mask !== e_pass) begin
            n_errors++; $display("FAIL %s hold: done=%b conf=%h pm=%h, want done 0 conf last pm %h",
                                 nm, done, bist_conf_reg, pass_mask, e_pass);
        end
    endtask

    task automatic test_directed();
        set_all_status(16'h0000);
        test_campaign(16'h0005, 1'b0, 8'h00, "d1_pass");
        status_tbl[15] = 16'hA5C3;
        test_campaign(16'h8001, 1'b0, 8'h00, "d2_fail15");
        set_all_status(16'h0000);
        status_tbl[16] = 16'h0002;
        test_campaign(16'h0000, 1'b1, 8'hFF, "d3_user");
        for (int i = 0; i < 17; i++) status_tbl[i] = 16'h1230 | 16'(i % 15 + 1);
        test_campaign(16'hFFFF, 1'b1, 8'h40, "d4_allfail");
        test_campaign(16'h0000, 1'b0, 8'h00, "d_empty");
    endtask

    task automatic test_random();
        logic [15:0] m;
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < 17; i++)
                status_tbl[i] = (16'($urandom) & 16'hFFF0) | ($urandom_range(0, 1) != 0 ? 16'h0 : 16'($urandom_range(1, 15)));
            m = 16'($urandom) & 16'($urandom);
            if (it == 3) m = '0;
            test_campaign(m, 1'($urandom_range(0, 1)), 8'($urandom), "rand");
        end
    endtask

    task automatic test_abort();
        int w, d0;
        set_all_status(16'h0000);
        d0 = done_cnt;
        @(posedge clk); #1;
        test_mask = 16'h0006; user_run = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        w = 0;
        do begin @(negedge clk); w++; end while (!(bist_enable && bist_conf_reg == 13'h200) && w < 200);
        n_checks++;
        if (w >= 200) begin n_errors++; $display("FAIL abort_wait: test 2 run not seen, want conf 200 enabled"); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        n_checks++;
        if (bist_enable !== 1'b0 || done !== 1'b1 || aborted !== 1'b1 || busy !== 1'b0) begin
            n_errors++; $display("FAIL abort_ctrl: en=%b done=%b ab=%b busy=%b, want 0 1 1 0", bist_enable, done, aborted, busy);
        end
        n_checks++;
        if (pass_mask !== 16'h0002 || fail_mask !== 16'h0000 || fail_count !== 5'd0 || first_fail_test !== 5'd31) begin
            n_errors++; $display("FAIL abort_results: pm=%h fm=%h fc=%0d fft=%0d, want 0002 0000 0 31",
                                 pass_mask, fail_mask, fail_count, first_fail_test);
        end
        @(negedge clk); #1;
        n_checks++;
        if (done_cnt - d0 !== 1 || run_len_q[run_len_q.size() - 1] !== 3) begin
            n_errors++; $display("FAIL abort_run: pulses=%0d last_len=%0d, want 1 3", done_cnt - d0, run_len_q[run_len_q.size() - 1]);
        end
        @(posedge clk); #1;
        test_mask = 16'h0001; start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || aborted !== 1'b1 || done_cnt - d0 !== 1) begin
            n_errors++; $display("FAIL idle_abort_start: busy=%b ab=%b pulses=%0d, want 0 1 1", busy, aborted, done_cnt - d0);
        end
    endtask

    task automatic test_busy_and_rst();
        int w, d0;
        set_all_status(16'h0000);
        status_tbl[0] = 16'h1234;
        d0 = done_cnt;
        @(posedge clk); #1;
        test_mask = 16'h0003; user_run = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        w = 0;
        do begin @(posedge clk); #1; w++; end while (!bist_enable && w < 50);
        test_mask = 16'h00F0; user_run = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        w = 0;
        while (!done && w < 200) begin @(posedge clk); #1; w++; end
        n_checks++;
        if (pass_mask !== 16'h0002 || fail_mask !== 16'h0001 || user_fail !== 1'b0 || first_fail_stat !== 16'h1234) begin
            n_errors++; $display("FAIL busy_start: pm=%h fm=%h uf=%b ffs=%h, want 0002 0001 0 1234",
                                 pass_mask, fail_mask, user_fail, first_fail_stat);
        end
        @(posedge clk); #1;
        d0 = done_cnt;
        test_mask = 16'h0003; user_run = 1'b1; user_len = 8'h11; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        w = 0;
        do begin @(posedge clk); #1; w++; end while (!(bist_enable && bist_conf_reg == 13'h100) && w < 100);
        n_checks++;
        if (fail_mask !== 16'h0001 || first_fail_test !== 5'd0 || busy !== 1'b1) begin
            n_errors++; $display("FAIL rst_precond: fm=%h fft=%0d busy=%b, want 0001 0 1", fail_mask, first_fail_test, busy);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if ({busy, done, bist_enable, aborted, pass_mask, fail_mask, user_fail, fail_count, first_fail_test, first_fail_stat, bist_conf_reg}
            !== {3'b000, 1'b0, 16'h0, 16'h0, 1'b0, 5'd0, 5'd31, 16'h0, 13'h0}) begin
            n_errors++;
            $display("FAIL rst_mid: busy=%b done=%b en=%b pm=%h fm=%h fc=%0d fft=%0d conf=%h, want reset values",
                     busy, done, bist_enable, pass_mask, fail_mask, fail_count, first_fail_test, bist_conf_reg);
        end
        repeat (20) @(posedge clk);
        #1;
        n_checks++;
        if (done_cnt !== d0 || busy !== 1'b0) begin
            n_errors++; $display("FAIL rst_no_done: pulses=%0d busy=%b, want 0 0", done_cnt - d0, busy);
        end
    endtask

    initial begin
        set_all_status(16'h0000);
        test_reset();
        test_directed();
        test_random();
        test_abort();
        test_busy_and_rst();
        test_campaign(16'h0101, 1'b1, 8'h08, "after_rst");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
